// File: rtl/monopulse_result_averager.sv
// monopulse_result_averager: boxcar average over the last 2**LOG2_WINDOW divider quotients.
module monopulse_result_averager #(
    parameter int DATA_SIZE   = 64,
    parameter int LOG2_WINDOW = 3
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic [2*DATA_SIZE-1:0] i_result,
    input  logic                   i_valid,
    input  logic                   i_clear,
    output logic [2*DATA_SIZE-1:0] o_average,
    output logic                   o_valid,
    output logic                   o_primed
);
    localparam int RES_W  = 2 * DATA_SIZE;
    localparam int WINDOW = 2 ** LOG2_WINDOW;
    localparam int ACC_W  = RES_W + LOG2_WINDOW;
    localparam logic [LOG2_WINDOW:0] WIN    = (LOG2_WINDOW + 1)'(WINDOW);
    localparam logic [LOG2_WINDOW:0] WIN_M1 = (LOG2_WINDOW + 1)'(WINDOW - 1);

    logic [RES_W-1:0]        r_buf [WINDOW];
    logic signed [ACC_W-1:0] r_acc;
    logic [LOG2_WINDOW-1:0]  r_wr_ptr;
    logic [LOG2_WINDOW:0]    r_count;
    logic signed [ACC_W-1:0] w_new, w_old, w_acc_n;
    logic                    w_full;

    // the oldest sample sits at the write pointer and leaves the sum as the new one enters
    always_comb begin
        w_new   = {{LOG2_WINDOW{i_result[RES_W-1]}}, i_result};
        w_old   = {{LOG2_WINDOW{r_buf[r_wr_ptr][RES_W-1]}}, r_buf[r_wr_ptr]};
        w_acc_n = r_acc + w_new - w_old;
        w_full  = r_count >= WIN_M1;
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < WINDOW; i++) r_buf[i] <= '0;
            r_acc     <= '0;
            r_wr_ptr  <= '0;
            r_count   <= '0;
            o_average <= '0;
            o_valid   <= 1'b0;
            o_primed  <= 1'b0;
        end else if (i_clear) begin
            for (int i = 0; i < WINDOW; i++) r_buf[i] <= '0;
            r_acc    <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            o_valid  <= 1'b0;
            o_primed <= 1'b0;
        end else if (i_valid) begin
            r_buf[r_wr_ptr] <= i_result;
            r_acc           <= w_acc_n;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
            r_count         <= w_full ? WIN : r_count + 1'b1;
            o_average       <= RES_W'(w_acc_n >>> LOG2_WINDOW);
            o_valid         <= w_full;
            o_primed        <= w_full;
        end else begin
            o_valid <= 1'b0;
        end
    end
endmodule
